// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if
//   Request and serial-stream bundle for seq_pattern_tx.
//   master : the requesting side. It drives start, pattern, len and repeat_n.
//   slave  : the transmitter. It drives dout, dout_valid, ready, frame_done, done and err.
// Signals
//   start      request. It is taken only on an edge where ready=1.
//   pattern    bits to send. pattern[len-1] goes out first.
//   len        frame length in bits (1..MAX_LEN).
//   repeat_n   the number of frames sent is repeat_n+1.
//   dout       serial data. It is 0 whenever dout_valid=0.
//   dout_valid dout carries a frame bit in this cycle.
//   ready      the transmitter is idle and will take a start.
//   frame_done pulse on the last bit of each frame.
//   done       pulse in the cycle after the last bit of the last frame.
//   err        pulse when a start is rejected because len is illegal.
interface seq_pattern_tx_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 4
);
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [CNT_W-1:0]   repeat_n;
    logic               dout;
    logic               dout_valid;
    logic               ready;
    logic               frame_done;
    logic               done;
    logic               err;

    modport master (
        output start, pattern, len, repeat_n,
        input  dout, dout_valid, ready, frame_done, done, err
    );

    modport slave (
        input  start, pattern, len, repeat_n,
        output dout, dout_valid, ready, frame_done, done, err
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
//   Serial bit-pattern transmitter. It shifts a captured pattern out MSB-first onto a
//   1-bit line. The frame can repeat repeat_n+1 times, with GAP_CYCLES idle cycles
//   between frames. It drives the din stream of the seq_fsm sequence detector.
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    seq_pattern_tx_if.slave. It carries start/pattern/len/repeat_n in and
//          dout/dout_valid/ready/frame_done/done/err out. All outputs are registered.
// Configuration
//   SEQ_TX_PARITY_EN : when this macro is defined, each frame gets one extra even-parity
//                      bit after pattern[0], and frame_done moves to that bit.
module seq_pattern_tx #(
    parameter int unsigned MAX_LEN    = 8,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    seq_pattern_tx_if.slave bus
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [LEN_W:0]   MAX_LEN_EXT = (LEN_W + 1)'(MAX_LEN);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SHIFT  = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
`ifdef SEQ_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic [2:0]         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   bit_q, bit_d;      // index of the next pattern bit to send
    logic [CNT_W-1:0]   frm_q, frm_d;      // frames left after the current one
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic               fdone_q, fdone_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef SEQ_TX_PARITY_EN
    logic               par_q, par_d;      // running XOR of the bits sent in this frame
`endif

    logic [MAX_LEN-1:0] shifted;
    logic               len_ok;
    logic               frame_end;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        bit_d     = bit_q;
        frm_d     = frm_q;
        gap_d     = gap_q;
        dout_d    = 1'b0;
        valid_d   = 1'b0;
        ready_d   = 1'b0;
        fdone_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        frame_end = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        par_d     = par_q;
`endif
        shifted = pat_q >> bit_q;
        len_ok  = (bus.len != '0) && ({1'b0, bus.len} <= MAX_LEN_EXT);

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                // ready_q is 0 in the cycle after done, so a start there is ignored.
                if (ready_q && bus.start) begin
                    if (len_ok) begin
                        pat_d   = bus.pattern;
                        len_d   = bus.len;
                        frm_d   = bus.repeat_n;
                        bit_d   = bus.len - LEN_W'(1);
                        state_d = ST_SHIFT;
                        ready_d = 1'b0;
`ifdef SEQ_TX_PARITY_EN
                        par_d   = 1'b0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                dout_d  = shifted[0];
                valid_d = 1'b1;
`ifdef SEQ_TX_PARITY_EN
                par_d   = par_q ^ shifted[0];
`endif
                if (bit_q == '0) begin
`ifdef SEQ_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    fdone_d   = 1'b1;
                    frame_end = 1'b1;
`endif
                end else begin
                    bit_d = bit_q - LEN_W'(1);
                end
            end
`ifdef SEQ_TX_PARITY_EN
            ST_PARITY: begin
                dout_d    = par_q;
                valid_d   = 1'b1;
                fdone_d   = 1'b1;
                frame_end = 1'b1;
            end
`endif
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The last bit of a frame has gone out: re-arm for the next frame or finish.
        if (frame_end) begin
            bit_d = len_q - LEN_W'(1);
`ifdef SEQ_TX_PARITY_EN
            par_d = 1'b0;
`endif
            if (frm_q != '0) begin
                frm_d = frm_q - CNT_W'(1);
                if (GAP_CYCLES > 0) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end else begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            frm_q   <= '0;
            gap_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            fdone_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            frm_q   <= frm_d;
            gap_q   <= gap_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            fdone_q <= fdone_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.ready      = ready_q;
    assign bus.frame_done = fdone_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx
//   Directed bench for seq_pattern_tx. The stimulus pushes the expected output events
//   into a queue. A monitor running on the falling edge pops one entry for every
//   cycle the DUT shows a bit, done or err, and compares that entry with the outputs.
module tb_seq_pattern_tx;

    localparam int unsigned MAX_LEN    = 8;
    localparam int unsigned LEN_W      = 4;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned GAP_CYCLES = 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_pattern_tx_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_pattern_tx #(
        .MAX_LEN   (MAX_LEN),
        .LEN_W     (LEN_W),
        .CNT_W     (CNT_W),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // code = {ready, done, err, frame_done, dout}
    // gap  = idle cycles expected before this event; -1 means no check
    typedef struct {
        int         gap;
        logic [4:0] code;
    } item_t;

    item_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_item(input int gap, input logic [4:0] code);
        item_t it;
        it.gap  = gap;
        it.code = code;
        q.push_back(it);
    endtask

    // bits holds the expected stream MSB-first in its low nbits positions.
    task automatic push_frames(input logic [15:0] bits, input int nbits, input int nframes);
        logic par;
        for (int f = 0; f < nframes; f++) begin
            par = 1'b0;
            for (int i = nbits - 1; i >= 0; i--) begin
                logic fd;
                fd = 1'b0;
`ifndef SEQ_TX_PARITY_EN
                fd = (i == 0);
`endif
                par ^= bits[i];
                push_item((i == nbits - 1) ? ((f == 0) ? -1 : int'(GAP_CYCLES)) : 0,
                          {1'b0, 1'b0, 1'b0, fd, bits[i]});
            end
`ifdef SEQ_TX_PARITY_EN
            push_item(0, {1'b0, 1'b0, 1'b0, 1'b1, par});
`endif
        end
        push_item(0, 5'b0_1_0_0_0);
    endtask

    // Call this task just after a rising edge. Start is held for exactly one edge.
    task automatic start_req(input logic [7:0] pat, input logic [3:0] l, input logic [3:0] rep);
        bus.start    = 1'b1;
        bus.pattern  = pat;
        bus.len      = l;
        bus.repeat_n = rep;
        @(posedge clk); #1;
        bus.start    = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || bus.ready !== 1'b1) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " drain"}, 32'((q.size() == 0 && bus.ready === 1'b1) ? 1 : 0), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor
    int         idle_cnt = 0;
    logic [4:0] act_code;
    item_t      exp_it;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.dout_valid !== 1'b1) check("dout zero when invalid", 32'(bus.dout), 32'd0);
            if (bus.dout_valid === 1'b1 || bus.done === 1'b1 || bus.err === 1'b1 ||
                bus.frame_done === 1'b1) begin
                act_code = {bus.ready, bus.done, bus.err, bus.frame_done, bus.dout};
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected event: got %b want none at %0t", act_code, $time);
                end else begin
                    exp_it = q.pop_front();
                    check("event code", 32'(act_code), 32'(exp_it.code));
                    if (exp_it.gap >= 0) check("event gap", 32'(idle_cnt), 32'(exp_it.gap));
                end
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.pattern  = '0;
        bus.len      = '0;
        bus.repeat_n = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 32'(bus.ready), 32'd1);
        check("reset dout_valid", 32'(bus.dout_valid), 32'd0);
        check("reset dout", 32'(bus.dout), 32'd0);
        check("reset frame_done", 32'(bus.frame_done), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Test 1: 101 sent once. Check the latency, ignore input changes, ignore a start during done.
        push_frames(16'b101, 3, 1);
        start_req(8'h05, 4'd3, 4'd0);
        bus.pattern = 8'hFF;
        bus.len     = 4'd7;
        check("t1 ready after accept", 32'(bus.ready), 32'd0);
        check("t1 no bit at accept", 32'(bus.dout_valid), 32'd0);
        @(posedge clk); #1;
        check("t1 first bit valid", 32'(bus.dout_valid), 32'd1);
        check("t1 first bit", 32'(bus.dout), 32'd1);
        repeat (3) @(posedge clk);
`ifdef SEQ_TX_PARITY_EN
        @(posedge clk);
`endif
        #1;
        check("t1 done pulse", 32'(bus.done), 32'd1);
        check("t1 ready in done", 32'(bus.ready), 32'd0);
        start_req(8'h07, 4'd3, 4'd0);
        check("t1 ready after done", 32'(bus.ready), 32'd1);
        check("t1 start in done ignored", 32'(bus.dout_valid), 32'd0);
        wait_drain("t1");

        // Test 2: three frames separated by gaps.
        push_frames(16'b101, 3, 3);
        start_req(8'h05, 4'd3, 4'd2);
        wait_drain("t2");

        // Test 3: illegal lengths.
        push_item(-1, 5'b1_0_1_0_0);
        start_req(8'h05, 4'd0, 4'd0);
        check("t3 ready len0", 32'(bus.ready), 32'd1);
        push_item(-1, 5'b1_0_1_0_0);
        start_req(8'h05, 4'd9, 4'd0);
        check("t3 ready len9", 32'(bus.ready), 32'd1);
        check("t3 no bits", 32'(bus.dout_valid), 32'd0);
        wait_drain("t3");

        // Test 4: a full-length frame with start re-asserted mid-frame.
        push_frames(16'b1010_0101, 8, 1);
        start_req(8'hA5, 4'd8, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.pattern = 8'hFF;
        bus.len     = 4'd8;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_drain("t4");

        // Test 5: reset after 2 of 8 bits, then an immediate new start.
        push_item(-1, 5'b0_0_0_0_1);
        push_item(0, 5'b0_0_0_0_0);
        start_req(8'hA5, 4'd8, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5 valid after reset", 32'(bus.dout_valid), 32'd0);
        check("t5 ready after reset", 32'(bus.ready), 32'd1);
        check("t5 no done after reset", 32'(bus.done), 32'd0);
        check("t5 queue consumed", 32'(q.size()), 32'd0);
        reset = 1'b0;
        push_frames(16'b0011_1100, 8, 1);
        start_req(8'h3C, 4'd8, 4'd0);
        wait_drain("t5");

        // Test 6: len=1 with repeat_n all-ones gives 16 frames.
        push_frames(16'b1, 1, 16);
        start_req(8'h01, 4'd1, 4'd15);
        wait_drain("t6");

`ifdef SEQ_TX_PARITY_EN
        // Test 7: parity bit appended.
        push_frames(16'b101, 3, 1);
        start_req(8'h05, 4'd3, 4'd0);
        wait_drain("t7a");
        push_frames(16'b111, 3, 1);
        start_req(8'h07, 4'd3, 4'd0);
        wait_drain("t7b");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
